id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the MIPS core, directly downstream of the register file. Samples the register file's two combinational read ports, resolves RAW hazards by forwarding from MEM and WB, detects load-use hazards and requests a one-cycle stall, then registers the resolved operands and control into the EX stage. It also counts stall cycles for performance monitoring.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID->EX pipeline register with MEM/WB operand forwarding,
//            load-use stall detection and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rs_i,
    input  logic        id_uses_rt_i,
    input  logic [31:0] id_rdata1_i,
    input  logic [31:0] id_rdata2_i,
    input  logic [4:0]  id_wadr_i,
    input  logic        id_we_i,
    input  logic        id_mem_rd_i,
    input  logic [31:0] id_imm_i,
    input  logic [4:0]  mem_wadr_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  wb_wadr_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic        ex_we_o,
    output logic        ex_mem_rd_o,
    output logic [4:0]  ex_wadr_o,
    output logic [31:0] ex_op1_o,
    output logic [31:0] ex_op2_o,
    output logic [31:0] ex_imm_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [4:0]  c_REG_ZERO = 5'd0;
    localparam logic [31:0] c_CNT_MAX  = 32'hFFFF_FFFF;

    logic        r_ex_valid;
    logic        r_ex_we;
    logic        r_ex_mem_rd;
    logic [4:0]  r_ex_wadr;
    logic [31:0] r_ex_op1;
    logic [31:0] r_ex_op2;
    logic [31:0] r_ex_imm;
    logic [31:0] r_stall_cnt;

    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_load_use;
    logic        w_bubble;

    // MEM holds the younger result, so it beats WB; WB beats the regfile
    // because the regfile write only lands on the coming edge.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_data,
        input logic [4:0]  m_adr,
        input logic        m_we,
        input logic [31:0] m_data,
        input logic [4:0]  w_adr,
        input logic        w_we,
        input logic [31:0] w_data
    );
        if (src == c_REG_ZERO)
            return 32'd0;
        else if (m_we && (m_adr == src))
            return m_data;
        else if (w_we && (w_adr == src))
            return w_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        w_op1 = fwd_sel(id_rs_i, id_rdata1_i, mem_wadr_i, mem_we_i, mem_wdata_i,
                        wb_wadr_i, wb_we_i, wb_wdata_i);
        w_op2 = fwd_sel(id_rt_i, id_rdata2_i, mem_wadr_i, mem_we_i, mem_wdata_i,
                        wb_wadr_i, wb_we_i, wb_wdata_i);
    end

    assign w_load_use = id_valid_i && r_ex_valid && r_ex_mem_rd
                        && (r_ex_wadr != c_REG_ZERO)
                        && ((id_uses_rs_i && (r_ex_wadr == id_rs_i))
                         || (id_uses_rt_i && (r_ex_wadr == id_rt_i)));
    // A redirect squashes the dependent instruction, so no stall is needed.
    assign stall_o  = w_load_use && !flush_i;
    assign w_bubble = flush_i || stall_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || w_bubble) begin
            r_ex_valid  <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_mem_rd <= 1'b0;
            r_ex_wadr   <= 5'd0;
            r_ex_op1    <= 32'd0;
            r_ex_op2    <= 32'd0;
            r_ex_imm    <= 32'd0;
        end else begin
            r_ex_valid  <= id_valid_i;
            r_ex_we     <= id_we_i && id_valid_i;
            r_ex_mem_rd <= id_mem_rd_i && id_valid_i;
            r_ex_wadr   <= id_wadr_i;
            r_ex_op1    <= w_op1;
            r_ex_op2    <= w_op2;
            r_ex_imm    <= id_imm_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            r_stall_cnt <= 32'd0;
        else if (stall_o && (r_stall_cnt != c_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign ex_valid_o  = r_ex_valid;
    assign ex_we_o     = r_ex_we;
    assign ex_mem_rd_o = r_ex_mem_rd;
    assign ex_wadr_o   = r_ex_wadr;
    assign ex_op1_o    = r_ex_op1;
    assign ex_op2_o    = r_ex_op2;
    assign ex_imm_o    = r_ex_imm;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Vector-table bench for id_ex_stage with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  wadr;
        logic        we;
        logic        mrd;
        logic [31:0] imm;
        logic [4:0]  mwa;
        logic        mwe;
        logic [31:0] mwd;
        logic [4:0]  wwa;
        logic        wwe;
        logic [31:0] wwd;
        logic        flush;
        logic        e_stall;
        logic        e_v;
        logic        e_we;
        logic        e_mrd;
        logic [4:0]  e_wadr;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [31:0] e_imm;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        id_valid_i, id_uses_rs_i, id_uses_rt_i, id_we_i, id_mem_rd_i;
    logic [4:0]  id_rs_i, id_rt_i, id_wadr_i, mem_wadr_i, wb_wadr_i;
    logic [31:0] id_rdata1_i, id_rdata2_i, id_imm_i, mem_wdata_i, wb_wdata_i;
    logic        mem_we_i, wb_we_i, flush_i;
    logic        stall_o, ex_valid_o, ex_we_o, ex_mem_rd_o;
    logic [4:0]  ex_wadr_o;
    logic [31:0] ex_op1_o, ex_op2_o, ex_imm_o, stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
        .id_wadr_i(id_wadr_i), .id_we_i(id_we_i), .id_mem_rd_i(id_mem_rd_i),
        .id_imm_i(id_imm_i),
        .mem_wadr_i(mem_wadr_i), .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i),
        .wb_wadr_i(wb_wadr_i), .wb_we_i(wb_we_i), .wb_wdata_i(wb_wdata_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_we_o(ex_we_o), .ex_mem_rd_o(ex_mem_rd_o),
        .ex_wadr_o(ex_wadr_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_imm_o(ex_imm_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic urs, input logic urt,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [4:0] wadr, input logic we, input logic mrd,
                                   input logic [31:0] imm);
        vec_t t = '0;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.rd1 = rd1; t.rd2 = rd2; t.wadr = wadr; t.we = we; t.mrd = mrd; t.imm = imm;
        return t;
    endfunction

    function automatic vec_t fwd(input vec_t t, input logic [4:0] mwa, input logic mwe,
                                 input logic [31:0] mwd, input logic [4:0] wwa,
                                 input logic wwe, input logic [31:0] wwd);
        vec_t r = t;
        r.mwa = mwa; r.mwe = mwe; r.mwd = mwd; r.wwa = wwa; r.wwe = wwe; r.wwd = wwd;
        return r;
    endfunction

    function automatic vec_t exp(input vec_t t, input logic st, input logic ev,
                                 input logic ewe, input logic emrd, input logic [4:0] ewadr,
                                 input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [31:0] eimm, input logic [31:0] cnt);
        vec_t r = t;
        r.e_stall = st; r.e_v = ev; r.e_we = ewe; r.e_mrd = emrd; r.e_wadr = ewadr;
        r.e_op1 = op1; r.e_op2 = op2; r.e_imm = eimm; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        id_valid_i = t.v; id_rs_i = t.rs; id_rt_i = t.rt;
        id_uses_rs_i = t.urs; id_uses_rt_i = t.urt;
        id_rdata1_i = t.rd1; id_rdata2_i = t.rd2;
        id_wadr_i = t.wadr; id_we_i = t.we; id_mem_rd_i = t.mrd; id_imm_i = t.imm;
        mem_wadr_i = t.mwa; mem_we_i = t.mwe; mem_wdata_i = t.mwd;
        wb_wadr_i = t.wwa; wb_we_i = t.wwe; wb_wdata_i = t.wwd;
        flush_i = t.flush;
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk_i);
        drive(t);
        #1;
        chk($sformatf("v%0d stall_o", idx), {31'd0, stall_o}, {31'd0, t.e_stall});
        sb.push_back(t);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d ctrl{v,we,mrd,wadr}", idx),
                {24'd0, ex_valid_o, ex_we_o, ex_mem_rd_o, ex_wadr_o},
                {24'd0, e.e_v, e.e_we, e.e_mrd, e.e_wadr});
            chk($sformatf("v%0d ex_op1_o", idx), ex_op1_o, e.e_op1);
            chk($sformatf("v%0d ex_op2_o", idx), ex_op2_o, e.e_op2);
            chk($sformatf("v%0d ex_imm_o", idx), ex_imm_o, e.e_imm);
            chk($sformatf("v%0d stall_cnt_o", idx), stall_cnt_o, e.e_cnt);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl"}, {24'd0, ex_valid_o, ex_we_o, ex_mem_rd_o, ex_wadr_o}, 32'd0);
        chk({tag, " op1"}, ex_op1_o, 32'd0);
        chk({tag, " op2"}, ex_op2_o, 32'd0);
        chk({tag, " imm"}, ex_imm_o, 32'd0);
        chk({tag, " cnt"}, stall_cnt_o, 32'd0);
        chk({tag, " stall_o"}, {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        vec_t lw7, use7, t;

        lw7  = instr(1, 2, 7, 1, 0, 32'h1000, 32'h0, 7, 1, 1, 32'h10);
        use7 = instr(1, 7, 3, 1, 1, 32'h0, 32'h33, 9, 1, 0, 32'h0);

        // add r8 = r3 + r4, no hazards
        vecs.push_back(exp(instr(1, 3, 4, 1, 1, 32'h11, 32'h22, 8, 1, 0, 0),
                           0, 1, 1, 0, 8, 32'h11, 32'h22, 0, 0));
        t = instr(1, 5, 6, 1, 1, 32'h55, 32'h66, 9, 1, 0, 32'h5);
        vecs.push_back(exp(fwd(t, 5, 1, 32'hAAAA, 5, 1, 32'hBBBB),
                           0, 1, 1, 0, 9, 32'hAAAA, 32'h66, 32'h5, 0));
        vecs.push_back(exp(fwd(t, 5, 0, 32'hAAAA, 5, 1, 32'hBBBB),
                           0, 1, 1, 0, 9, 32'hBBBB, 32'h66, 32'h5, 0));
        // r0 is never forwarded
        vecs.push_back(exp(fwd(instr(1, 0, 4, 1, 1, 32'h77, 32'h22, 10, 1, 0, 0),
                               0, 1, 32'hDEAD, 0, 1, 32'hBEEF),
                           0, 1, 1, 0, 10, 32'h0, 32'h22, 0, 0));
        // load-use on rs: one bubble, then MEM forward
        vecs.push_back(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 0));
        vecs.push_back(exp(use7, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(exp(fwd(use7, 7, 1, 32'h1234, 0, 0, 0),
                           0, 1, 1, 0, 9, 32'h1234, 32'h33, 0, 1));
        // hazard coinciding with flush: no stall, no count
        vecs.push_back(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 1));
        t = instr(1, 3, 7, 1, 1, 32'h33, 32'h0, 9, 1, 0, 0);
        t.flush = 1'b1;
        vecs.push_back(exp(t, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // load followed by an instruction that does not read the loaded reg
        vecs.push_back(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 1));
        vecs.push_back(exp(instr(1, 7, 7, 0, 0, 32'h70, 32'h71, 12, 1, 0, 0),
                           0, 1, 1, 0, 12, 32'h70, 32'h71, 0, 1));
        // load into r0 never stalls
        vecs.push_back(exp(instr(1, 2, 0, 1, 0, 32'h1000, 0, 0, 1, 1, 32'h4),
                           0, 1, 1, 1, 0, 32'h1000, 0, 32'h4, 1));
        vecs.push_back(exp(instr(1, 0, 0, 1, 1, 0, 0, 13, 1, 0, 0),
                           0, 1, 1, 0, 13, 0, 0, 0, 1));
        // load-use on rt, resolved via WB path
        vecs.push_back(exp(instr(1, 2, 10, 1, 0, 32'h1000, 0, 10, 1, 1, 32'h8),
                           0, 1, 1, 1, 10, 32'h1000, 0, 32'h8, 1));
        t = instr(1, 4, 10, 1, 1, 32'h44, 32'h0, 14, 1, 0, 0);
        vecs.push_back(exp(t, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(exp(fwd(t, 0, 0, 0, 10, 1, 32'hCAFE),
                           0, 1, 1, 0, 14, 32'h44, 32'hCAFE, 0, 2));
        // load, dependent load, dependent use: one stall per pair
        vecs.push_back(exp(instr(1, 2, 11, 1, 0, 32'h1000, 0, 11, 1, 1, 0),
                           0, 1, 1, 1, 11, 32'h1000, 0, 0, 2));
        t = instr(1, 11, 12, 1, 0, 0, 0, 12, 1, 1, 0);
        vecs.push_back(exp(t, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(exp(fwd(t, 11, 1, 32'h2000, 0, 0, 0),
                           0, 1, 1, 1, 12, 32'h2000, 0, 0, 3));
        t = instr(1, 12, 5, 1, 1, 0, 32'h55, 15, 1, 0, 0);
        vecs.push_back(exp(t, 1, 0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(exp(fwd(t, 12, 1, 32'h3000, 0, 0, 0),
                           0, 1, 1, 0, 15, 32'h3000, 32'h55, 0, 4));
        // invalid ID slot: control gated, data still loaded
        vecs.push_back(exp(instr(0, 7, 7, 1, 1, 32'h70, 32'h71, 7, 1, 1, 32'h9),
                           0, 0, 0, 0, 7, 32'h70, 32'h71, 32'h9, 4));

        rst_n_i = 1'b0;
        drive('0);
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // reset during a stall cycle
        apply(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 4), 100);
        @(negedge clk_i);
        drive(use7);
        #1;
        chk("midstall stall_o before reset", {31'd0, stall_o}, 32'd1);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_all_zero("midstall reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // saturation from a preset counter value
        dut.r_stall_cnt = 32'hFFFF_FFFE;
        apply(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 32'hFFFF_FFFE), 200);
        apply(exp(use7, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF), 201);
        apply(exp(lw7, 0, 1, 1, 1, 7, 32'h1000, 32'h0, 32'h10, 32'hFFFF_FFFF), 202);
        apply(exp(use7, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF), 203);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
